// File: rtl/pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pulse_scheduler
// Description : Shares one pulse-train generator between four requesters.
//               Each requester owns a programmable pulse width and pulse
//               count. A round-robin arbiter picks one requester at a time.
//               The FSM then plays that requester's train on `signal` and
//               flags completion with a one-cycle one-hot `done` strobe.
//
// Ports       : clock      - system clock, all state on posedge
//               reset      - synchronous, active-high
//               cfg_we     - config write strobe
//               cfg_sel    - requester index being configured
//               cfg_width  - high time and inter-pulse low time (cycles)
//               cfg_count  - pulses per train
//               req        - level requests, one bit per requester
//               grant      - one-hot, requester being served
//               busy       - high while a train is in HIGH/LOW
//               signal     - shared pulse output
//               done       - one-hot, one-cycle completion strobe
//
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_scheduler #(
    parameter int NREQ = 4,
    parameter int W_W  = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_sel,
    input  logic [W_W-1:0]  cfg_width,
    input  logic [W_W-1:0]  cfg_count,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            signal,
    output logic [NREQ-1:0] done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HIGH = 2'd1;
    localparam logic [1:0] c_LOW  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Per-requester configuration
    logic [W_W-1:0]  r_width [NREQ];
    logic [W_W-1:0]  r_count [NREQ];

    // FSM and train datapath
    logic [1:0]      r_state;
    logic [1:0]      r_ptr;        // last requester served
    logic [W_W-1:0]  r_wm1;        // latched width minus one
    logic [W_W-1:0]  r_tmr;        // cycles left in current window, minus one
    logic [W_W-1:0]  r_rem;        // pulses still to emit, including current
    logic [NREQ-1:0] r_grant;
    logic            r_busy;
    logic            r_signal;
    logic [NREQ-1:0] r_done;

    logic [1:0]      w_state_nxt;
    logic            w_found;
    logic [1:0]      w_pick;
    logic [1:0]      w_cand;
    logic [W_W-1:0]  w_lat_w;
    logic [W_W-1:0]  w_lat_c;
    logic            w_win_end;
    logic [NREQ-1:0] w_grant_nxt;
    logic            w_busy_nxt;
    logic            w_signal_nxt;
    logic [NREQ-1:0] w_done_nxt;

    // ------------------------------------------------------------------
    // Configuration registers. A write to the active requester only
    // lands here; the running train uses its own latched copies.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_width[i] <= W_W'(4);
                r_count[i] <= W_W'(1);
            end
        end else if (cfg_we) begin
            r_width[cfg_sel] <= cfg_width;
            r_count[cfg_sel] <= cfg_count;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first set request bit scanning upward from
    // r_ptr+1. The last candidate (k = NREQ) wraps back to r_ptr itself.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Stored zero is treated as one when latched
    assign w_lat_w   = (r_width[w_pick] == '0) ? W_W'(1) : r_width[w_pick];
    assign w_lat_c   = (r_count[w_pick] == '0) ? W_W'(1) : r_count[w_pick];
    assign w_win_end = (r_tmr == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_HIGH;
                end
            end
            c_HIGH: begin
                if (w_win_end) begin
                    w_state_nxt = (r_rem > W_W'(1)) ? c_LOW : c_DONE;
                end
            end
            c_LOW: begin
                if (w_win_end) begin
                    w_state_nxt = c_HIGH;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Produces the values the output registers take
    // on the next edge, so every port comes straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_signal_nxt = (w_state_nxt == c_HIGH);
        w_busy_nxt   = (w_state_nxt == c_HIGH) || (w_state_nxt == c_LOW);
        w_grant_nxt  = '0;
        w_done_nxt   = '0;
        if (r_state == c_IDLE && w_found) begin
            w_grant_nxt = NREQ'(1) << w_pick;
        end else if (w_busy_nxt) begin
            w_grant_nxt = r_grant;
        end
        if (r_state == c_HIGH && w_state_nxt == c_DONE) begin
            w_done_nxt = r_grant;
        end
    end

    // ------------------------------------------------------------------
    // Output registers and train datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr    <= 2'd3;          // req[0] has top priority first
            r_wm1    <= '0;
            r_tmr    <= '0;
            r_rem    <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_signal <= 1'b0;
            r_done   <= '0;
        end else begin
            r_grant  <= w_grant_nxt;
            r_busy   <= w_busy_nxt;
            r_signal <= w_signal_nxt;
            r_done   <= w_done_nxt;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_ptr <= w_pick;
                        r_wm1 <= w_lat_w - W_W'(1);
                        r_tmr <= w_lat_w - W_W'(1);
                        r_rem <= w_lat_c;
                    end
                end
                c_HIGH: begin
                    if (w_win_end) begin
                        r_tmr <= r_wm1;
                        if (r_rem > W_W'(1)) begin
                            r_rem <= r_rem - W_W'(1);
                        end
                    end else begin
                        r_tmr <= r_tmr - W_W'(1);
                    end
                end
                c_LOW: begin
                    if (w_win_end) begin
                        r_tmr <= r_wm1;
                    end else begin
                        r_tmr <= r_tmr - W_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign grant  = r_grant;
    assign busy   = r_busy;
    assign signal = r_signal;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pulse_scheduler
// Description : Self-checking bench for pulse_scheduler. Table-driven
//               vectors for the default and programmed trains, hand-written
//               sequences for round-robin, zero config, mid-train config /
//               request drop and mid-train reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [3:0] cfg_width;
    logic [3:0] cfg_count;
    logic [3:0] req;
    logic [3:0] grant;
    logic       busy;
    logic       signal;
    logic [3:0] done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       we;
        logic [1:0] sel;
        logic [3:0] wid;
        logic [3:0] cnt;
        logic [3:0] rq;
        logic [3:0] e_grant;
        logic       e_busy;
        logic       e_sig;
        logic [3:0] e_done;
    } vec_t;

    vec_t tbl[$];

    pulse_scheduler #(.NREQ(4), .W_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_width (cfg_width),
        .cfg_count (cfg_count),
        .req       (req),
        .grant     (grant),
        .busy      (busy),
        .signal    (signal),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge, then sit 1ns past it for sampling/driving
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        cfg_we = 1'b0;
        req    = 4'b0000;
        step();
        step();
        reset  = 1'b0;
    endtask

    function automatic void addv(input logic we, input logic [1:0] sel,
                                 input logic [3:0] wid, input logic [3:0] cnt,
                                 input logic [3:0] rq, input logic [3:0] g,
                                 input logic b, input logic s, input logic [3:0] d);
        vec_t v;
        v.we = we; v.sel = sel; v.wid = wid; v.cnt = cnt; v.rq = rq;
        v.e_grant = g; v.e_busy = b; v.e_sig = s; v.e_done = d;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [14:0] pat;
        logic [14:0] obs;
        logic [3:0]  gseq   [5];
        logic [3:0]  dseq   [5];
        logic [3:0]  rr_exp [5];
        logic [3:0]  prevg;
        logic        bad;
        int          ng;
        int          nd;
        int          n;

        reset = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0;
        cfg_width = 4'd0; cfg_count = 4'd0; req = 4'b0000;
        step();
        step();
        check("reset_grant",  32'(grant),  32'h0);
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_signal", 32'(signal), 32'h0);
        check("reset_done",   32'(done),   32'h0);
        reset = 1'b0;

        // Default train on req[0]: 4 high cycles, then done[0]
        for (int i = 0; i < 4; i++) addv(0, 0, 0, 0, 4'b0001, 4'b0001, 1, 1, 4'b0000);
        addv(0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 4'b0001);
        addv(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
        addv(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
        // Programmed train on req[2]: width 3, count 3
        addv(1, 2, 3, 3, 4'b0000, 4'b0000, 0, 0, 4'b0000);
        pat = 15'b111000111000111;
        for (int i = 14; i >= 0; i--) addv(0, 0, 0, 0, 4'b0100, 4'b0100, 1, pat[i], 4'b0000);
        addv(0, 0, 0, 0, 4'b0100, 4'b0000, 0, 0, 4'b0100);
        addv(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            cfg_we    = tbl[i].we;
            cfg_sel   = tbl[i].sel;
            cfg_width = tbl[i].wid;
            cfg_count = tbl[i].cnt;
            req       = tbl[i].rq;
            step();
            check($sformatf("vec%0d_grant", i),  32'(grant),  32'(tbl[i].e_grant));
            check($sformatf("vec%0d_busy", i),   32'(busy),   32'(tbl[i].e_busy));
            check($sformatf("vec%0d_signal", i), 32'(signal), 32'(tbl[i].e_sig));
            check($sformatf("vec%0d_done", i),   32'(done),   32'(tbl[i].e_done));
        end
        cfg_we = 1'b0;

        // Round-robin with all requesters asserted
        do_reset();
        for (int s = 0; s < 4; s++) begin
            cfg_we = 1'b1; cfg_sel = 2'(s); cfg_width = 4'd2; cfg_count = 4'd1;
            step();
        end
        cfg_we = 1'b0;
        req = 4'b1111;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin gseq[k] = 4'b0000; dseq[k] = 4'b0000; end
        ng = 0; nd = 0; prevg = 4'b0000;
        for (int cyc = 0; cyc < 60 && nd < 5; cyc++) begin
            step();
            if (grant != 4'b0000 && prevg == 4'b0000 && ng < 5) begin
                gseq[ng] = grant;
                ng++;
            end
            if (done != 4'b0000 && nd < 5) begin
                dseq[nd] = done;
                nd++;
            end
            prevg = grant;
        end
        check("rr_grant_count", 32'(ng), 32'd5);
        check("rr_done_count",  32'(nd), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_grant%0d", k), 32'(gseq[k]), 32'(rr_exp[k]));
            check($sformatf("rr_done%0d", k),  32'(dseq[k]), 32'(rr_exp[k]));
        end
        req = 4'b0000;

        // Zero config is treated as width 1, count 1
        do_reset();
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_width = 4'd0; cfg_count = 4'd0;
        step();
        cfg_we = 1'b0;
        req = 4'b0010;
        step();
        check("zero_sig_high", 32'(signal), 32'h1);
        check("zero_grant",    32'(grant),  32'h2);
        step();
        check("zero_sig_low",  32'(signal), 32'h0);
        check("zero_done",     32'(done),   32'h2);
        req = 4'b0000;
        step();
        check("zero_done_clr", 32'(done),   32'h0);

        // Mid-train config write and request drop on requester 3
        do_reset();
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_width = 4'd5; cfg_count = 4'd2;
        step();
        cfg_we = 1'b0;
        req = 4'b1000;
        step();
        obs[14] = signal;
        bad = (grant !== 4'b1000);
        for (int i = 1; i < 15; i++) begin
            if (i == 3) begin
                cfg_we = 1'b1; cfg_sel = 2'd3; cfg_width = 4'd1; cfg_count = 4'd1;
                req = 4'b0000;
            end else begin
                cfg_we = 1'b0;
            end
            step();
            obs[14-i] = signal;
            if (grant !== 4'b1000) bad = 1'b1;
        end
        cfg_we = 1'b0;
        check("mid_pattern", 32'(obs), 32'(15'b111110000011111));
        check("mid_grant_held", 32'(bad), 32'h0);
        step();
        check("mid_done",   32'(done),   32'h8);
        check("mid_signal", 32'(signal), 32'h0);

        // Reset during HIGH of a width-8 train
        do_reset();
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_width = 4'd8; cfg_count = 4'd1;
        step();
        cfg_we = 1'b0;
        req = 4'b0001;
        step();
        step();
        step();
        check("rstmid_pre_sig", 32'(signal), 32'h1);
        reset = 1'b1;
        req = 4'b0000;
        step();
        reset = 1'b0;
        check("rstmid_signal", 32'(signal), 32'h0);
        check("rstmid_busy",   32'(busy),   32'h0);
        check("rstmid_grant",  32'(grant),  32'h0);
        bad = (done !== 4'b0000);
        for (int i = 0; i < 12; i++) begin
            step();
            if (done !== 4'b0000 || signal !== 1'b0) bad = 1'b1;
        end
        check("rstmid_no_done", 32'(bad), 32'h0);
        // Config must be back at width 4, count 1
        req = 4'b0001;
        step();
        n = 0;
        while (signal === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check("rstmid_default_width", 32'(n), 32'd4);
        check("rstmid_default_done",  32'(done), 32'h1);
        req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
